magic_streamer_multi_slot: RTL and testbench

MAGIC_STREAMER_MULTI_SLOT -- requirements
Module: magic_streamer_multi_slot

---
 rtl/magic_streamer_multi_slot.sv | 160 ++++++++++++++++
 tb/tb_magic_streamer_multi_slot.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_streamer_multi_slot.sv
// Multi-slot AXI-Stream capture/replay buffer: store a packet into one of NUM_SLOTS
// block-RAM slots, then replay it any number of times on the load stream.
module magic_streamer_multi_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_TKEEP,
    input  logic                    S_AXI_TVALID,
    input  logic                    S_AXI_TLAST,
    output logic                    S_AXI_TREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
    output logic                    M_AXI_TVALID,
    output logic                    M_AXI_TLAST,
    input  logic                    M_AXI_TREADY,
    input  logic [SLOT_W-1:0]       cmd_slot,
    input  logic                    store_init,
    input  logic                    load_init,
    input  logic                    slot_clear,
    input  logic                    abort,
    output logic                    busy,
    output logic                    fin_store,
    output logic                    fin_load,
    output logic                    store_overflow,
    output logic [2:0]              dbg_state,
    output logic [DEPTH_LOG2:0]     dbg_store_cnt,
    output logic [DEPTH_LOG2:0]     dbg_load_cnt
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = SLOT_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {IDLE = 3'd0, STORE = 3'd1, LOAD = 3'd2} state_t;

    state_t state_reg, state_next;

    logic [KW+DATA_WIDTH-1:0] mem [2**AW];
    logic [KW+DATA_WIDTH-1:0] q_reg;
    logic [DEPTH_LOG2:0]      len_reg [NUM_SLOTS];
    logic [SLOT_W-1:0]        slot_reg;
    logic [DEPTH_LOG2:0]      wr_cnt_reg, rd_idx_reg, load_cnt_reg;
    logic                     m_valid_reg, m_last_reg;
    logic                     fin_store_reg, fin_load_reg, overflow_reg;

    logic                     cmd_ok, s_beat, wr_en, m_fire, advance, rd_issue;
    logic                     store_done, load_done, clear_hit, store_start, load_start;
    logic [DEPTH_LOG2:0]      cur_len;

    always_comb begin
        state_next  = state_reg;
        clear_hit   = 1'b0;
        store_start = 1'b0;
        load_start  = 1'b0;
        cmd_ok      = ({1'b0, cmd_slot} < (SLOT_W+1)'(NUM_SLOTS));
        cur_len     = len_reg[slot_reg];
        s_beat      = (state_reg == STORE) && S_AXI_TVALID;
        wr_en       = s_beat && (wr_cnt_reg < CAP);
        m_fire      = m_valid_reg && M_AXI_TREADY;
        // The output register doubles as the RAM read register, so a new read
        // may only be issued when the current beat is absent or being taken.
        advance     = !m_valid_reg || M_AXI_TREADY;
        rd_issue    = (state_reg == LOAD) && !abort && advance && (rd_idx_reg < cur_len);
        store_done  = (state_reg == STORE) && !abort && s_beat && S_AXI_TLAST;
        load_done   = (state_reg == LOAD) && !abort &&
                      ((m_fire && m_last_reg) || (!m_valid_reg && rd_idx_reg >= cur_len));

        case (state_reg)
            IDLE: begin
                if (slot_clear && cmd_ok) begin
                    clear_hit = 1'b1;
                end else if (store_init && cmd_ok) begin
                    store_start = 1'b1;
                    state_next  = STORE;
                end else if (load_init && cmd_ok) begin
                    load_start = 1'b1;
                    state_next = LOAD;
                end
            end
            STORE: begin
                if (abort || store_done) state_next = IDLE;
            end
            LOAD: begin
                if (abort || load_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            wr_cnt_reg    <= '0;
            rd_idx_reg    <= '0;
            load_cnt_reg  <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            fin_store_reg <= 1'b0;
            fin_load_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) len_reg[i] <= '0;
        end else begin
            state_reg     <= state_next;
            fin_store_reg <= store_done;
            fin_load_reg  <= load_done;
            if (clear_hit) begin
                len_reg[cmd_slot] <= '0;
                overflow_reg      <= 1'b0;
            end
            if (store_start) begin
                len_reg[cmd_slot] <= '0;
                slot_reg          <= cmd_slot;
                wr_cnt_reg        <= '0;
            end
            if (load_start) begin
                slot_reg     <= cmd_slot;
                rd_idx_reg   <= '0;
                load_cnt_reg <= '0;
            end
            // Length tracks the write count so an abort keeps what was written.
            if (wr_en) begin
                wr_cnt_reg        <= wr_cnt_reg + 1'b1;
                len_reg[slot_reg] <= wr_cnt_reg + 1'b1;
            end
            if (s_beat && !wr_en) overflow_reg <= 1'b1;
            if (rd_issue) rd_idx_reg <= rd_idx_reg + 1'b1;
            if ((state_reg == LOAD) && m_fire) load_cnt_reg <= load_cnt_reg + 1'b1;
            if ((state_reg != LOAD) || abort) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end else if (advance) begin
                m_valid_reg <= rd_issue;
                m_last_reg  <= rd_issue && (rd_idx_reg == cur_len - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{slot_reg, wr_cnt_reg[DEPTH_LOG2-1:0]}] <= {S_AXI_TKEEP, S_AXI_TDATA};
        if (rd_issue) q_reg <= mem[{slot_reg, rd_idx_reg[DEPTH_LOG2-1:0]}];
    end

    assign S_AXI_TREADY   = (state_reg == STORE);
    assign busy           = (state_reg != IDLE);
    assign M_AXI_TVALID   = m_valid_reg;
    assign M_AXI_TLAST    = m_valid_reg && m_last_reg;
    assign M_AXI_TDATA    = m_valid_reg ? q_reg[DATA_WIDTH-1:0] : '0;
    assign M_AXI_TKEEP    = m_valid_reg ? q_reg[KW+DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign fin_store      = fin_store_reg;
    assign fin_load       = fin_load_reg;
    assign store_overflow = overflow_reg;
    assign dbg_state      = state_reg;
    assign dbg_store_cnt  = wr_cnt_reg;
    assign dbg_load_cnt   = load_cnt_reg;
endmodule

// File: tb/tb_magic_streamer_multi_slot.sv
// Scoreboard bench: a default-depth instance and a 4-deep instance share the store
// stream; loads are steered to one instance and checked beat by beat.
module tb_magic_streamer_multi_slot;
    localparam int DW = 32;
    localparam int KW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] S_AXI_TDATA;
    logic [KW-1:0] S_AXI_TKEEP;
    logic          S_AXI_TVALID, S_AXI_TLAST, M_AXI_TREADY;
    logic [1:0]    cmd_slot;
    logic          store_init, load_init, slot_clear, abort;
    logic          sel;

    logic [DW-1:0] b_tdata, s_tdata;
    logic [KW-1:0] b_tkeep, s_tkeep;
    logic          b_tvalid, s_tvalid, b_tlast, s_tlast, b_sready, s_sready;
    logic          b_busy, s_busy, b_fs, s_fs, b_fl, s_fl, b_ovf, s_ovf;
    logic [2:0]    b_state, s_state;
    logic [10:0]   b_scnt, b_lcnt;
    logic [2:0]    s_scnt, s_lcnt;

    magic_streamer_multi_slot dut_big (
        .clk(clk), .reset(reset),
        .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
        .S_AXI_TLAST(S_AXI_TLAST), .S_AXI_TREADY(b_sready),
        .M_AXI_TDATA(b_tdata), .M_AXI_TKEEP(b_tkeep), .M_AXI_TVALID(b_tvalid),
        .M_AXI_TLAST(b_tlast), .M_AXI_TREADY(M_AXI_TREADY),
        .cmd_slot(cmd_slot), .store_init(store_init), .load_init(load_init && !sel),
        .slot_clear(slot_clear), .abort(abort),
        .busy(b_busy), .fin_store(b_fs), .fin_load(b_fl), .store_overflow(b_ovf),
        .dbg_state(b_state), .dbg_store_cnt(b_scnt), .dbg_load_cnt(b_lcnt)
    );

    magic_streamer_multi_slot #(.DEPTH_LOG2(2)) dut_small (
        .clk(clk), .reset(reset),
        .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
        .S_AXI_TLAST(S_AXI_TLAST), .S_AXI_TREADY(s_sready),
        .M_AXI_TDATA(s_tdata), .M_AXI_TKEEP(s_tkeep), .M_AXI_TVALID(s_tvalid),
        .M_AXI_TLAST(s_tlast), .M_AXI_TREADY(M_AXI_TREADY),
        .cmd_slot(cmd_slot), .store_init(store_init), .load_init(load_init && sel),
        .slot_clear(slot_clear), .abort(abort),
        .busy(s_busy), .fin_store(s_fs), .fin_load(s_fl), .store_overflow(s_ovf),
        .dbg_state(s_state), .dbg_store_cnt(s_scnt), .dbg_load_cnt(s_lcnt)
    );

    logic [DW-1:0] o_tdata;
    logic [KW-1:0] o_tkeep;
    logic          o_tvalid, o_tlast, o_sready, o_busy, o_fs, o_fl;
    logic [10:0]   o_scnt, o_lcnt;
    assign o_tdata  = sel ? s_tdata  : b_tdata;
    assign o_tkeep  = sel ? s_tkeep  : b_tkeep;
    assign o_tvalid = sel ? s_tvalid : b_tvalid;
    assign o_tlast  = sel ? s_tlast  : b_tlast;
    assign o_sready = sel ? s_sready : b_sready;
    assign o_busy   = sel ? s_busy   : b_busy;
    assign o_fs     = sel ? s_fs     : b_fs;
    assign o_fl     = sel ? s_fl     : b_fl;
    assign o_scnt   = sel ? 11'(s_scnt) : b_scnt;
    assign o_lcnt   = sel ? 11'(s_lcnt) : b_lcnt;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    logic [DW-1:0] mdata [2][4][8];
    logic [KW-1:0] mkeep [2][4][8];
    int  mlen [2][4];
    int  cap [2] = '{1024, 4};
    bit  rst_done;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int slot);
        cmd_slot = slot[1:0];
        slot_clear = 1'b1;
        step;
        slot_clear = 1'b0;
        for (int d = 0; d < 2; d++) mlen[d][slot] = 0;
    endtask

    task automatic do_store(input int slot, input logic [DW-1:0] base, input int n, input bit do_abort);
        int expn;
        cmd_slot = slot[1:0];
        store_init = 1'b1;
        step;
        store_init = 1'b0;
        checks++;
        if (o_sready !== 1'b1 || o_busy !== 1'b1)
            $display("FAIL store_enter slot%0d tready=%b busy=%b want 1 1", slot, o_sready, o_busy);
        for (int i = 0; i < n; i++) begin
            S_AXI_TVALID = 1'b1;
            S_AXI_TDATA  = base + DW'(i);
            S_AXI_TKEEP  = (i % 2 == 1) ? 4'h3 : 4'hF;
            S_AXI_TLAST  = !do_abort && (i == n - 1);
            for (int d = 0; d < 2; d++) begin
                if (i < cap[d]) begin
                    mdata[d][slot][i] = S_AXI_TDATA;
                    mkeep[d][slot][i] = S_AXI_TKEEP;
                end
            end
            step;
        end
        for (int d = 0; d < 2; d++) mlen[d][slot] = (n < cap[d]) ? n : cap[d];
        S_AXI_TVALID = 1'b0;
        S_AXI_TLAST  = 1'b0;
        if (do_abort) begin
            abort = 1'b1;
            step;
            abort = 1'b0;
            checks++;
            if (o_busy !== 1'b0 || o_fs !== 1'b0)
                $display("FAIL store_abort busy=%b fin_store=%b want 0 0", o_busy, o_fs);
        end else begin
            checks++;
            if (o_fs !== 1'b1) $display("FAIL fin_store got %b want 1", o_fs);
            checks++;
            if (o_busy !== 1'b0) $display("FAIL store_busy got %b want 0", o_busy);
        end
        if (o_fs !== (do_abort ? 1'b0 : 1'b1)) errors++;
        if (o_busy !== 1'b0) errors++;
        expn = mlen[sel][slot];
        checks++;
        if (o_scnt !== 11'(expn)) begin
            errors++;
            $display("FAIL store_cnt got %0d want %0d", o_scnt, expn);
        end
        step;
        checks++;
        if (o_fs !== 1'b0) begin
            errors++;
            $display("FAIL fin_store_pulse got %b want 0", o_fs);
        end
        $display("store slot%0d beats=%0d abort=%0d len=%0d", slot, n, do_abort, expn);
    endtask

    task automatic do_load(input int d, input int slot, input int mode, input int rst_at);
        int n, k, got, first;
        bit fin_seen, stop, pv, pr;
        beat_t pb, cur, e;
        sel = d[0];
        n = mlen[d][slot];
        for (int i = 0; i < n; i++)
            exp_q.push_back('{data: mdata[d][slot][i], keep: mkeep[d][slot][i], last: (i == n - 1)});
        cmd_slot = slot[1:0];
        load_init = 1'b1;
        step;
        load_init = 1'b0;
        k = 0; got = 0; first = -1; fin_seen = 0; stop = 0; pv = 0; pr = 0; pb = '0;
        while (!fin_seen && !stop && k < 100) begin
            M_AXI_TREADY = (mode == 0) ? 1'b1 : (k % 3 == 0);
            cur = '{data: o_tdata, keep: o_tkeep, last: o_tlast};
            if (o_fl) begin
                fin_seen = 1;
                checks++;
                if (o_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL load_end_valid got %b want 0", o_tvalid);
                end
                checks++;
                if (got != n) begin
                    errors++;
                    $display("FAIL load_count got %0d want %0d", got, n);
                end
                if (n == 0) begin
                    checks++;
                    if (k != 1) begin
                        errors++;
                        $display("FAIL empty_fin_latency got %0d want 1", k);
                    end
                end
            end else if (rst_at >= 0 && got == rst_at && o_tvalid) begin
                reset = 1'b1;
                step;
                checks++;
                if (o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset tvalid=%b busy=%b want 0 0", o_tvalid, o_busy);
                end
                reset = 1'b0;
                exp_q.delete();
                for (int dd = 0; dd < 2; dd++)
                    for (int s = 0; s < 4; s++) mlen[dd][s] = 0;
                rst_done = 1;
                stop = 1;
            end else begin
                if (o_tvalid && first < 0) begin
                    first = k;
                    checks++;
                    if (k > 2) begin
                        errors++;
                        $display("FAIL first_valid_latency got %0d want <=2", k);
                    end
                end
                if (pv && !pr) begin
                    checks++;
                    if (!o_tvalid || cur !== pb) begin
                        errors++;
                        $display("FAIL stall_hold got %b/%h want 1/%h", o_tvalid, cur, pb);
                    end
                end
                if (mode == 0 && first >= 0 && got < n) begin
                    checks++;
                    if (!o_tvalid) begin
                        errors++;
                        $display("FAIL bubble at cycle %0d got valid 0 want 1", k);
                    end
                end
                if (o_tvalid && M_AXI_TREADY) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat got %h want none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL beat%0d got %h want %h", got, cur, e);
                        end
                    end
                    $display("load slot%0d beat%0d data=%h keep=%h last=%b", slot, got, cur.data, cur.keep, cur.last);
                    got++;
                end
                pv = o_tvalid;
                pr = M_AXI_TREADY;
                pb = cur;
                step;
                k++;
            end
        end
        M_AXI_TREADY = 1'b0;
        if (!stop) begin
            checks++;
            if (!fin_seen) begin
                errors++;
                $display("FAIL load_timeout got no fin_load want fin_load");
            end
            checks++;
            if (o_lcnt !== 11'(n)) begin
                errors++;
                $display("FAIL load_cnt got %0d want %0d", o_lcnt, n);
            end
            step;
            checks++;
            if (o_fl !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL fin_load_pulse fin=%b busy=%b want 0 0", o_fl, o_busy);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_beats got %0d want 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) step;
        checks++;
        if ({b_busy, b_fs, b_fl, b_ovf, b_tvalid, b_tlast, b_sready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000", {b_busy, b_fs, b_fl, b_ovf, b_tvalid, b_tlast, b_sready});
        end
        checks++;
        if (b_tdata !== '0 || b_tkeep !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", b_tdata, b_tkeep);
        end
        checks++;
        if (b_state !== 3'd0 || b_scnt !== '0 || b_lcnt !== '0) begin
            errors++;
            $display("FAIL reset_dbg got %0d/%0d/%0d want 0/0/0", b_state, b_scnt, b_lcnt);
        end
        checks++;
        if ({s_busy, s_ovf, s_tvalid, s_sready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_small got %b want 0000", {s_busy, s_ovf, s_tvalid, s_sready});
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_store;
        sel = 1'b0;
        do_store(1, 32'h10, 5, 1'b0);
    endtask

    task automatic test_load_ready;
        do_load(0, 1, 0, -1);
    endtask

    task automatic test_load_stall;
        do_load(0, 1, 1, -1);
        do_load(0, 1, 0, -1);
    endtask

    task automatic test_overflow;
        sel = 1'b1;
        do_clear(3);
        checks++;
        if (s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow got %b want 0", s_ovf);
        end
        do_store(3, 32'hA0, 6, 1'b0);
        checks++;
        if (s_ovf !== 1'b1 || b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow small=%b big=%b want 1 0", s_ovf, b_ovf);
        end
        do_load(1, 3, 0, -1);
        do_load(1, 3, 1, -1);
    endtask

    task automatic test_clear_empty;
        sel = 1'b0;
        do_clear(1);
        do_load(0, 1, 0, -1);
    endtask

    task automatic test_abort;
        sel = 1'b0;
        do_store(2, 32'h30, 3, 1'b1);
        do_load(0, 2, 1, -1);
    endtask

    task automatic test_reset_mid_load;
        sel = 1'b0;
        rst_done = 0;
        do_store(1, 32'h50, 5, 1'b0);
        do_load(0, 1, 0, 2);
        checks++;
        if (!rst_done) begin
            errors++;
            $display("FAIL mid_reset_reached got 0 want 1");
        end
        step;
        for (int s = 0; s < 4; s++) do_load(0, s, 0, -1);
    endtask

    initial begin
        S_AXI_TDATA = '0; S_AXI_TKEEP = '0; S_AXI_TVALID = 1'b0; S_AXI_TLAST = 1'b0;
        M_AXI_TREADY = 1'b0; cmd_slot = '0; sel = 1'b0;
        store_init = 1'b0; load_init = 1'b0; slot_clear = 1'b0; abort = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) mlen[d][s] = 0;
        test_reset;
        test_store;
        test_load_ready;
        test_load_stall;
        test_overflow;
        test_clear_empty;
        test_abort;
        test_reset_mid_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
